// File: rtl/csa_pkg.sv
// Shared types and sizing helpers for the pipelined carry-skip adder/subtractor.
package csa_pkg;

  typedef enum logic {OP_ADD = 1'b0, OP_SUB = 1'b1} csa_op_e;

  function automatic int nblk(input int width, input int blk);
    return width / blk;
  endfunction

  function automatic int bps(input int width, input int blk, input int stages);
    return (width / blk) / stages;
  endfunction

endpackage

// File: rtl/csa_skip_block.sv
// One carry-skip block: ripple carry inside, skip mux on the block carry-out.
module csa_skip_block #(
  parameter int BLK = 4
) (
  input  logic [BLK-1:0] a,
  input  logic [BLK-1:0] b,
  input  logic           cin,
  output logic [BLK-1:0] sum,
  output logic           cout,
  output logic           msb_cin
);

  logic [BLK-1:0] p;
  logic [BLK-1:0] g;
  logic [BLK:0]   c;

  // When every bit propagates, the incoming carry bypasses the ripple chain.
  always_comb begin
    p    = a ^ b;
    g    = a & b;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < BLK; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
    sum     = p ^ c[BLK-1:0];
    msb_cin = c[BLK-1];
    cout    = (&p) ? cin : c[BLK];
  end

endmodule

// File: rtl/csa_pipe_addsub.sv
// Parametrised pipelined carry-skip adder/subtractor with valid/ready on both sides.
// Define CSA_PIPE_OVF_EN to generate the registered signed-overflow output.
module csa_pipe_addsub
  import csa_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int BLK    = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int NBLK = nblk(WIDTH, BLK);
  localparam int BPS  = bps(WIDTH, BLK, STAGES);
  localparam int LAST = STAGES - 1;

  if ((WIDTH % BLK) != 0) begin : g_err_width
    $error("csa_pipe_addsub: WIDTH must be a multiple of BLK");
  end
  if ((NBLK % STAGES) != 0) begin : g_err_stages
    $error("csa_pipe_addsub: WIDTH/BLK must be a multiple of STAGES");
  end

  csa_op_e op;
  assign op = csa_op_e'(in_op);

  logic [STAGES-1:0]                valid_q, valid_d;
  logic [STAGES-1:0]                carry_q, carry_d;
  logic [STAGES-1:0][WIDTH-1:0]     a_q, a_d;
  logic [STAGES-1:0][WIDTH-1:0]     b_q, b_d;
  logic [STAGES-1:0][WIDTH-1:0]     sum_q, sum_d;

  logic [STAGES-1:0]                adv;
  logic [STAGES-1:0]                src_v;
  logic [STAGES-1:0]                src_c;
  logic [STAGES-1:0][WIDTH-1:0]     src_a;
  logic [STAGES-1:0][WIDTH-1:0]     src_b;
  logic [STAGES-1:0][WIDTH-1:0]     src_s;
  logic [STAGES-1:0][WIDTH-1:0]     stage_sum;
  logic [STAGES-1:0]                stage_cout;
  logic [STAGES-1:0][BPS-1:0][BLK-1:0] blk_sum;
  logic [STAGES-1:0][BPS-1:0]       blk_msb;

  // A stage may load when it is empty or its contents move on this edge.
  always_comb begin
    adv       = '0;
    adv[LAST] = !valid_q[LAST] || out_ready;
    for (int k = LAST - 1; k >= 0; k--) begin
      adv[k] = !valid_q[k] || adv[k+1];
    end
  end

  // Stage 0 works on the raw inputs (B already inverted for SUB); later stages
  // work on the registers of the stage before them.
  always_comb begin
    src_v    = '0;
    src_c    = '0;
    src_a    = '0;
    src_b    = '0;
    src_s    = '0;
    src_v[0] = in_valid;
    src_c[0] = in_cin;
    src_a[0] = in_a;
    src_b[0] = (op == OP_SUB) ? ~in_b : in_b;
    for (int k = 1; k < STAGES; k++) begin
      src_v[k] = valid_q[k-1];
      src_c[k] = carry_q[k-1];
      src_a[k] = a_q[k-1];
      src_b[k] = b_q[k-1];
      src_s[k] = sum_q[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    for (genvar j = 0; j < BPS; j++) begin : g_blk
      logic blk_cin;
      logic blk_cout;
      if (j == 0) begin : g_first
        assign blk_cin = src_c[k];
      end else begin : g_chain
        assign blk_cin = g_blk[j-1].blk_cout;
      end
      csa_skip_block #(.BLK(BLK)) u_blk (
        .a       (src_a[k][(k*BPS+j)*BLK +: BLK]),
        .b       (src_b[k][(k*BPS+j)*BLK +: BLK]),
        .cin     (blk_cin),
        .sum     (blk_sum[k][j]),
        .cout    (blk_cout),
        .msb_cin (blk_msb[k][j])
      );
    end
    assign stage_cout[k] = g_blk[BPS-1].blk_cout;
  end

  always_comb begin
    stage_sum = src_s;
    for (int k = 0; k < STAGES; k++) begin
      for (int j = 0; j < BPS; j++) begin
        stage_sum[k][(k*BPS+j)*BLK +: BLK] = blk_sum[k][j];
      end
    end
  end

  // Data registers only load with a real operation so outputs hold after a bubble.
  always_comb begin
    valid_d = valid_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    for (int k = 0; k < STAGES; k++) begin
      if (adv[k]) begin
        valid_d[k] = src_v[k];
      end
      if (adv[k] && src_v[k]) begin
        carry_d[k] = stage_cout[k];
        a_d[k]     = src_a[k];
        b_d[k]     = src_b[k];
        sum_d[k]   = stage_sum[k];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      carry_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
    end else begin
      valid_q <= valid_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
    end
  end

`ifdef CSA_PIPE_OVF_EN
  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q;
    if (adv[LAST] && src_v[LAST]) begin
      ovf_d = blk_msb[LAST][BPS-1] ^ stage_cout[LAST];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign out_ovf = ovf_q;
`else
  assign out_ovf = 1'b0;
`endif

  // Operand copies in the final stage and inner-block MSB carries have no reader.
  logic unused_sink;
  assign unused_sink = ^{a_q[LAST], b_q[LAST], blk_msb};

  assign in_ready  = adv[0];
  assign out_valid = valid_q[LAST];
  assign out_sum   = sum_q[LAST];
  assign out_cout  = carry_q[LAST];

endmodule
